bus_arb: RTL and testbench

BUS_ARB -- requirements
Module: bus_arb

---
 rtl/bus_arb.sv | 100 ++++++++++
 tb/tb_bus_arb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb.sv
// Round-robin arbiter that sequences one master at a time through a fixed
// four-state bus access: IDLE -> ACCESS -> CAPTURE -> DONE.
module bus_arb #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 17,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]            en_mask,
    output logic [NUM_MASTERS-1:0]            m_gnt,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic [ADDR_WIDTH-1:0]             bus_addr,
    output logic                              bus_we,
    output logic [DATA_WIDTH-1:0]             bus_wdata,
    input  logic [DATA_WIDTH-1:0]             bus_rdata,
    output logic                              busy
);

    localparam int OWNER_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

    state_t                   state, state_next;
    logic [OWNER_W-1:0]       owner, last_owner, winner;
    logic [NUM_MASTERS-1:0]   eligible;
    logic [NUM_MASTERS-1:0]   owner_onehot;
    logic                     found;
    logic                     latched_we;
    int                       idx;

    assign eligible = m_req & en_mask;

    // Search starts just past the previous owner so every eligible master gets a turn.
    always_comb begin
        winner = last_owner;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = (int'(last_owner) + i) % NUM_MASTERS;
            if (!found && eligible[idx]) begin
                winner = OWNER_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = ACCESS;
            ACCESS:  state_next = CAPTURE;
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus address/data stay latched after the access until the next winner replaces them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= '0;
            last_owner <= OWNER_W'(NUM_MASTERS - 1);
            latched_we <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            m_rdata    <= '0;
        end else begin
            if (state == IDLE && found) begin
                owner      <= winner;
                last_owner <= winner;
                latched_we <= m_we[winner];
                bus_addr   <= m_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                bus_wdata  <= m_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state == CAPTURE) m_rdata <= bus_rdata;
        end
    end

    always_comb begin
        owner_onehot        = '0;
        owner_onehot[owner] = 1'b1;
    end

    assign m_gnt  = (state != IDLE) ? owner_onehot : '0;
    assign m_ack  = (state == DONE) ? owner_onehot : '0;
    assign bus_we = (state == ACCESS) && latched_we;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb with two masters and a registered bus controller
// model that returns bus_addr[7:0] ^ 8'h3C one cycle after the address.
module tb_bus_arb;

    localparam int NM = 2;
    localparam int AW = 17;
    localparam int DW = 8;

    logic              clk;
    logic              reset;
    logic [NM-1:0]     m_req;
    logic [NM-1:0]     m_we;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM-1:0]     en_mask;
    logic [NM-1:0]     m_gnt;
    logic [NM-1:0]     m_ack;
    logic [DW-1:0]     m_rdata;
    logic [AW-1:0]     bus_addr;
    logic              bus_we;
    logic [DW-1:0]     bus_wdata;
    logic [DW-1:0]     bus_rdata;
    logic              busy;

    int errors = 0;
    int checks = 0;

    bus_arb #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .en_mask(en_mask), .m_gnt(m_gnt), .m_ack(m_ack),
        .m_rdata(m_rdata), .bus_addr(bus_addr), .bus_we(bus_we),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus_rdata <= bus_addr[7:0] ^ 8'h3C;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NM-1:0] req, input logic [NM-1:0] mask);
        m_req   = req;
        en_mask = mask;
    endtask

    task automatic setMaster(input int i, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m_we[i]             = we;
        m_addr[i*AW +: AW]  = addr;
        m_wdata[i*DW +: DW] = wdata;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " gnt"},   32'(m_gnt),     32'h0);
        checkOutput({tag, " ack"},   32'(m_ack),     32'h0);
        checkOutput({tag, " busy"},  32'(busy),      32'h0);
        checkOutput({tag, " we"},    32'(bus_we),    32'h0);
        checkOutput({tag, " addr"},  32'(bus_addr),  32'h0);
        checkOutput({tag, " wdata"}, 32'(bus_wdata), 32'h0);
        checkOutput({tag, " rdata"}, 32'(m_rdata),   32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NM-1:0] exp;
        reset   = 1'b1;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        en_mask = 2'b11;
        repeat (2) cycle();
        checkIdleOutputs("reset");
        reset = 1'b0;

        $display("[TB] single read from master 0");
        setMaster(0, 1'b0, 17'h00010, 8'h00);
        applyStimulus(2'b01, 2'b11);
        cycle();
        checkOutput("rd access gnt",  32'(m_gnt),    32'h1);
        checkOutput("rd access addr", 32'(bus_addr), 32'h10);
        checkOutput("rd access we",   32'(bus_we),   32'h0);
        checkOutput("rd access ack",  32'(m_ack),    32'h0);
        cycle();
        checkOutput("rd capture ack", 32'(m_ack),    32'h0);
        checkOutput("rd capture gnt", 32'(m_gnt),    32'h1);
        cycle();
        checkOutput("rd done ack",    32'(m_ack),    32'h1);
        checkOutput("rd done rdata",  32'(m_rdata),  32'h2C);
        m_req = '0;
        cycle();
        checkOutput("rd idle busy",   32'(busy),     32'h0);
        checkOutput("rd idle ack",    32'(m_ack),    32'h0);
        checkOutput("rd rdata hold",  32'(m_rdata),  32'h2C);

        $display("[TB] single write from master 1");
        setMaster(1, 1'b1, 17'h1FFFF, 8'hA5);
        applyStimulus(2'b10, 2'b11);
        cycle();
        checkOutput("wr access gnt",   32'(m_gnt),     32'h2);
        checkOutput("wr access we",    32'(bus_we),    32'h1);
        checkOutput("wr access addr",  32'(bus_addr),  32'h1FFFF);
        checkOutput("wr access wdata", 32'(bus_wdata), 32'hA5);
        cycle();
        checkOutput("wr capture we",   32'(bus_we),    32'h0);
        cycle();
        checkOutput("wr done ack",     32'(m_ack),     32'h2);
        checkOutput("wr done rdata",   32'(m_rdata),   32'hC3);
        m_req = '0;
        cycle();
        checkOutput("wr idle ack",     32'(m_ack),     32'h0);
        checkOutput("wr addr hold",    32'(bus_addr),  32'h1FFFF);

        $display("[TB] contention from reset");
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        setMaster(0, 1'b0, 17'h00005, 8'h11);
        setMaster(1, 1'b0, 17'h00A00, 8'h22);
        applyStimulus(2'b11, 2'b11);
        for (int t = 0; t < 4; t++) begin
            exp = (t % 2 == 0) ? 2'b01 : 2'b10;
            cycle();
            checkOutput("cont access gnt", 32'(m_gnt), 32'(exp));
            checkOutput("cont onehot", $countones(m_gnt), 32'h1);
            cycle();
            checkOutput("cont capture gnt", 32'(m_gnt), 32'(exp));
            cycle();
            checkOutput("cont done ack", 32'(m_ack), 32'(exp));
            checkOutput("cont done rdata", 32'(m_rdata), (t % 2 == 0) ? 32'h39 : 32'h3C);
            cycle();
            checkOutput("cont idle gnt", 32'(m_gnt), 32'h0);
        end

        $display("[TB] en_mask blocks master 0");
        applyStimulus(2'b11, 2'b10);
        for (int t = 0; t < 2; t++) begin
            cycle();
            checkOutput("mask access gnt", 32'(m_gnt), 32'h2);
            cycle();
            cycle();
            checkOutput("mask done ack", 32'(m_ack), 32'h2);
            cycle();
            checkOutput("mask idle ack", 32'(m_ack), 32'h0);
        end
        m_req = '0;

        $display("[TB] withdrawal during capture");
        applyStimulus(2'b01, 2'b11);
        cycle();
        checkOutput("wd access gnt", 32'(m_gnt), 32'h1);
        cycle();
        m_req = '0;
        cycle();
        checkOutput("wd done ack", 32'(m_ack), 32'h1);
        cycle();
        checkOutput("wd idle busy", 32'(busy), 32'h0);
        cycle();
        checkOutput("wd stay idle busy", 32'(busy), 32'h0);
        checkOutput("wd stay idle gnt",  32'(m_gnt), 32'h0);

        $display("[TB] reset during capture");
        setMaster(1, 1'b0, 17'h00077, 8'hA5);
        applyStimulus(2'b10, 2'b11);
        cycle();
        checkOutput("rst access gnt", 32'(m_gnt), 32'h2);
        cycle();
        reset = 1'b1;
        #1;
        checkIdleOutputs("rst mid");
        cycle();
        checkOutput("rst held ack", 32'(m_ack), 32'h0);
        reset = 1'b0;
        applyStimulus(2'b11, 2'b11);
        cycle();
        checkOutput("rst first winner", 32'(m_gnt), 32'h1);
        checkOutput("rst first addr", 32'(bus_addr), 32'h5);
        m_req = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
